// File: rtl/rv_muldiv_unit.sv
// rv_muldiv_unit: iterative RV32M/RV64M multiply/divide unit.
//   One shared datapath, one bit per cycle: shift-add multiply and
//   restoring division on absolute operand values, with sign fix-up
//   applied in a final FIX cycle.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid/in_ready     request handshake (in_ready high only in IDLE)
//   op[2:0]               funct3: MUL MULH MULHSU MULHU DIV DIVU REM REMU
//   a, b                  rs1 / rs2 operands, captured at accept
//   flush                 synchronous abort, highest priority
//   out_valid/out_ready   response handshake, result held under back-pressure
//   result                operation result
//   busy                  high whenever not IDLE
module rv_muldiv_unit #(
  parameter  int XLEN  = 32,
  localparam int CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  localparam logic [XLEN-1:0] ONES = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]      op_q;
  logic            neg_q;   // negate the final product / quotient / remainder
  logic [XLEN-1:0] hi;      // product high half, or partial remainder
  logic [XLEN-1:0] lo;      // multiplier / product low half, or dividend / quotient
  logic [XLEN-1:0] opd;     // multiplicand or divisor (absolute value)

  // ---------------- accept-time decode ----------------
  logic            a_sgn_op, b_sgn_op, a_neg, b_neg, neg_in;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] special_res;

  always_comb begin
    // Multiplies: a signed except MULHU, b signed only for MUL/MULH.
    // Divides: even funct3 (DIV/REM) are signed.
    a_sgn_op = op[2] ? ~op[0] : ~(op[1] & op[0]);
    b_sgn_op = op[2] ? ~op[0] : ~op[1];
    a_neg    = a_sgn_op & a[XLEN-1];
    b_neg    = b_sgn_op & b[XLEN-1];
    abs_a    = a_neg ? -a : a;
    abs_b    = b_neg ? -b : b;
    // Remainder takes the dividend's sign; everything else the XOR.
    neg_in   = (op[2] & op[1]) ? a_neg : (a_neg ^ b_neg);

    div_zero = op[2] && (b == '0);
    div_ovf  = op[2] && !op[0] && (a == MINV) && (b == ONES);
    special  = div_zero || div_ovf;
    if (div_zero) special_res = op[1] ? a : ONES;
    else          special_res = op[1] ? '0 : a;
  end

  // ---------------- one iteration step ----------------
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   div_shift;
  logic [XLEN-1:0] div_diff;
  logic            div_ge;
  logic [XLEN-1:0] hi_nxt, lo_nxt;

  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, opd} : '0);
    div_shift = {hi, lo[XLEN-1]};
    div_ge    = (div_shift >= {1'b0, opd});
    // When div_ge holds the true difference is < opd, so XLEN bits suffice.
    div_diff  = div_shift[XLEN-1:0] - opd;
    if (op_q[2]) begin
      hi_nxt = div_ge ? div_diff : div_shift[XLEN-1:0];
      lo_nxt = {lo[XLEN-2:0], div_ge};
    end else begin
      hi_nxt = mul_sum[XLEN:1];
      lo_nxt = {mul_sum[0], lo[XLEN-1:1]};
    end
  end

  // ---------------- sign fix-up and result select ----------------
  logic [2*XLEN-1:0] prod_n;
  logic [XLEN-1:0]   quo_n, rem_n, fix_res;

  always_comb begin
    prod_n = neg_q ? -{hi, lo} : {hi, lo};
    quo_n  = neg_q ? -lo : lo;
    rem_n  = neg_q ? -hi : hi;
    case (op_q)
      3'b000:                fix_res = prod_n[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_n[2*XLEN-1:XLEN];
      3'b100, 3'b101:        fix_res = quo_n;
      default:               fix_res = rem_n;
    endcase
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      opd       <= '0;
      result    <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else if (flush) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          op_q     <= op;
          neg_q    <= neg_in;
          cnt      <= '0;
          hi       <= '0;
          lo       <= op[2] ? abs_a : abs_b;
          opd      <= op[2] ? abs_b : abs_a;
          in_ready <= 1'b0;
          busy     <= 1'b1;
          if (special) begin
            result    <= special_res;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            state <= S_CALC;
          end
        end
        S_CALC: begin
          hi  <= hi_nxt;
          lo  <= lo_nxt;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(XLEN-1)) state <= S_FIX;
        end
        S_FIX: begin
          result    <= fix_res;
          out_valid <= 1'b1;
          state     <= S_DONE;
        end
        default: if (out_ready) begin
          // in_ready only returns on the edge after the handshake.
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Directed bench for rv_muldiv_unit (XLEN=32) with a result scoreboard.
module tb_rv_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, out_ready, flush;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        in_ready, out_valid, busy;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;
  logic [31:0] sb_q[$];

  rv_muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns just after the accepting posedge.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    int n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    chk("in_ready_wait", {63'd0, in_ready}, 64'd1);
    op = o; a = x; b = y; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 3'($urandom); a = $urandom; b = $urandom;
  endtask

  // Counts edges after accept until out_valid is seen high.
  task automatic wait_out(output int lat);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!out_valid && lat < 200);
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y, input logic [31:0] exp, input int exp_lat);
    int lat;
    logic [31:0] e;
    sb_q.push_back(exp);
    issue(o, x, y);
    wait_out(lat);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    e = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
    chk(tag, {32'd0, result}, {32'd0, e});
    @(posedge clk);   // handshake with out_ready=1
    @(negedge clk);
  endtask

  initial begin
    int lat;
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    op = '0; a = '0; b = '0;
    #12;
    chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_busy",      {63'd0, busy},      64'd0);
    chk("rst_result",    {32'd0, result},    64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    run_op("mul_7_m3",   3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    run_op("mulh_min",   3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
    run_op("mulhu_ones", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    run_op("mulhsu",     3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34);
    run_op("mul_zero",   3'b000, 32'd0,         32'h1234_5678, 32'd0,         34);
    run_op("div_m7_2",   3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 34);
    run_op("rem_m7_2",   3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 34);
    run_op("div_20_m3",  3'b100, 32'd20,        32'hFFFF_FFFD, 32'hFFFF_FFFA, 34);
    run_op("rem_20_m3",  3'b110, 32'd20,        32'hFFFF_FFFD, 32'd2,         34);
    run_op("divu_100_7", 3'b101, 32'd100,       32'd7,         32'd14,        34);
    run_op("remu_100_7", 3'b111, 32'd100,       32'd7,         32'd2,         34);
    run_op("divu_by0",   3'b101, 32'd100,       32'd0,         32'hFFFF_FFFF, 1);
    run_op("remu_by0",   3'b111, 32'd100,       32'd0,         32'd100,       1);
    run_op("rem_by0",    3'b110, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 1);
    run_op("div_ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

    // Back-pressure; issue() also scrambles a/b after accept.
    out_ready = 1'b0;
    sb_q.push_back(32'd14);
    issue(3'b101, 32'd100, 32'd7);
    repeat (5) begin @(negedge clk); a = $urandom; b = $urandom; end
    wait_out(lat);
    chk("bp_lat", 64'(lat + 5), 64'd34);
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold", {31'd0, out_valid, in_ready, result}, {31'd0, 1'b1, 1'b0, sb_q[0]});
      @(negedge clk);
    end
    void'(sb_q.pop_front());
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release", {62'd0, in_ready, out_valid}, {62'd0, 1'b1, 1'b0});

    // flush while idle with a pending request: not accepted
    op = 3'b000; a = 32'd3; b = 32'd5; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1; in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_idle", {62'd0, busy, in_ready}, {62'd0, 1'b0, 1'b1});

    // flush at iteration 5
    issue(3'b000, 32'd9, 32'd9);
    repeat (5) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk);
    #1; flush = 1'b0;
    @(negedge clk);
    chk("flush_calc", {61'd0, in_ready, out_valid, busy}, {61'd0, 1'b1, 1'b0, 1'b0});
    seen = 0;
    repeat (40) begin @(negedge clk); if (out_valid) seen++; end
    chk("flush_no_out", 64'(seen), 64'd0);

    // reset mid-CALC
    issue(3'b100, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("rst_mid", {29'd0, in_ready, out_valid, busy, result}, {29'd0, 1'b1, 1'b0, 1'b0, 32'd0});
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (40) begin @(negedge clk); if (out_valid) seen++; end
    chk("rst_no_out", 64'(seen), 64'd0);

    run_op("mul_3_5", 3'b000, 32'd3, 32'd5, 32'd15, 34);

    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
